// File: rtl/alpha_seq_pkg.sv
// Shared state encoding and default sizing for the HDR alpha gain sequencer.
package alpha_seq_pkg;

   localparam int WEIGHT_W_DEF = 6;
   localparam int SETTLE_W_DEF = 12;
   localparam int ACK_TO_DEF   = 64;

   typedef enum logic [2:0] {
      LOW,
      REQ_UP,
      SETTLE,
      RAMP_UP,
      HIGH,
      REQ_DOWN
   } state_t;

endpackage

// File: rtl/mix_ramp_gen.sv
// Crossfade weight generator: a prescaler dividing by 2^ramp_shift feeding a
// saturating up-counter, with synchronous clear and a full-scale flag.
module mix_ramp_gen #(
   parameter int WEIGHT_W = 6
) (
   input  logic                CLK_3M,
   input  logic                reset,
   input  logic                clr_i,
   input  logic                step_i,
   input  logic [2:0]          ramp_shift_i,
   output logic [WEIGHT_W-1:0] weight_o,
   output logic                full_o
);

   localparam logic [WEIGHT_W-1:0] FULL = '1;

   logic [7:0]          presc_q, presc_d;
   logic [WEIGHT_W-1:0] weight_q, weight_d;
   logic [7:0]          prescTop;

   assign prescTop = 8'((16'd1 << ramp_shift_i) - 16'd1);

   // >= rather than == keeps the prescaler from running away if ramp_shift shrinks mid-ramp
   always_comb begin
      presc_d  = presc_q;
      weight_d = weight_q;
      if (clr_i) begin
         presc_d  = '0;
         weight_d = '0;
      end else if (step_i) begin
         if (presc_q >= prescTop) begin
            presc_d = '0;
            if (weight_q != FULL) begin
               weight_d = weight_q + WEIGHT_W'(1);
            end
         end else begin
            presc_d = presc_q + 8'd1;
         end
      end
   end

   always_ff @(posedge CLK_3M or negedge reset) begin
      if (!reset) begin
         presc_q  <= '0;
         weight_q <= '0;
      end else begin
         presc_q  <= presc_d;
         weight_q <= weight_d;
      end
   end

   assign weight_o = weight_q;
   assign full_o   = (weight_q == FULL);

endmodule

// File: rtl/alpha_gain_sequencer.sv
// HDR gain switchover sequencer: AFE req/ack handshake, settle wait, crossfade
// ramp up on alpha rise, immediate weight drop and gain-down on alpha fall.
module alpha_gain_sequencer
   import alpha_seq_pkg::*;
#(
   parameter int WEIGHT_W = WEIGHT_W_DEF,
   parameter int SETTLE_W = SETTLE_W_DEF,
   parameter int ACK_TO   = ACK_TO_DEF
) (
   input  logic                CLK_3M,
   input  logic                reset,
   input  logic                enable_i,
   input  logic                alpha_in_i,
   input  logic [SETTLE_W-1:0] settle_cycles_i,
   input  logic [2:0]          ramp_shift_i,
   input  logic                afe_ack_i,
   output logic                afe_req_o,
   output logic                afe_gain_hi_o,
   output logic                gain_sel_o,
   output logic [WEIGHT_W-1:0] mix_weight_o,
   output logic                busy_o,
   output logic                fault_o
);

   localparam int               ACK_W    = $clog2(ACK_TO + 1);
   localparam logic [ACK_W-1:0] ACK_LAST = ACK_W'(ACK_TO - 1);

   state_t              state_q, state_d;
   logic                alpha_q, enable_q;
   logic                afeReq_q, afeReq_d;
   logic                gainHi_q, gainHi_d;
   logic                gainSel_q, gainSel_d;
   logic                fault_q, fault_d;
   logic                busy_q, busy_d;
   logic [SETTLE_W-1:0] settleCnt_q, settleCnt_d;
   logic [ACK_W-1:0]    ackCnt_q, ackCnt_d;
   logic                upOk;
   logic                rampClr, rampStep, rampFull;
   logic [WEIGHT_W-1:0] rampWeight;

   assign upOk = enable_q & alpha_q & ~fault_q;

   // Outputs are computed alongside the next state so they land in registers with it
   always_comb begin
      state_d     = state_q;
      afeReq_d    = afeReq_q;
      gainHi_d    = gainHi_q;
      gainSel_d   = gainSel_q;
      fault_d     = fault_q;
      settleCnt_d = settleCnt_q;
      ackCnt_d    = '0;
      rampClr     = 1'b1;
      rampStep    = 1'b0;
      case (state_q)
         LOW: begin
            afeReq_d  = 1'b0;
            gainSel_d = 1'b0;
            if (!enable_q) begin
               fault_d = 1'b0;
            end
            if (upOk) begin
               state_d  = REQ_UP;
               gainHi_d = 1'b1;
               afeReq_d = ~afe_ack_i;
            end
         end
         REQ_UP, REQ_DOWN: begin
            ackCnt_d = ackCnt_q + ACK_W'(1);
            if (afeReq_q && afe_ack_i) begin
               afeReq_d = 1'b0;
               ackCnt_d = '0;
               if (state_q == REQ_UP) begin
                  state_d     = SETTLE;
                  gainSel_d   = 1'b1;
                  settleCnt_d = settle_cycles_i;
               end else begin
                  state_d   = LOW;
                  gainSel_d = 1'b0;
               end
            end else if (ackCnt_q == ACK_LAST) begin
               state_d   = LOW;
               afeReq_d  = 1'b0;
               gainSel_d = 1'b0;
               fault_d   = 1'b1;
               ackCnt_d  = '0;
            end else if (!afeReq_q && !afe_ack_i) begin
               afeReq_d = 1'b1;
               ackCnt_d = '0;
            end
         end
         SETTLE, RAMP_UP, HIGH: begin
            if (state_q != SETTLE) begin
               rampClr  = ~upOk;
               rampStep = upOk && (state_q == RAMP_UP);
            end
            if (!upOk) begin
               state_d  = REQ_DOWN;
               gainHi_d = 1'b0;
               afeReq_d = ~afe_ack_i;
            end else if (state_q == SETTLE) begin
               if (settleCnt_q == '0) begin
                  state_d = RAMP_UP;
               end else begin
                  settleCnt_d = settleCnt_q - SETTLE_W'(1);
               end
            end else if (state_q == RAMP_UP && rampFull) begin
               state_d = HIGH;
            end
         end
         default: begin
            state_d = LOW;
         end
      endcase
      busy_d = !(state_d == LOW || state_d == HIGH);
   end

   always_ff @(posedge CLK_3M or negedge reset) begin
      if (!reset) begin
         state_q     <= LOW;
         alpha_q     <= 1'b0;
         enable_q    <= 1'b0;
         afeReq_q    <= 1'b0;
         gainHi_q    <= 1'b0;
         gainSel_q   <= 1'b0;
         fault_q     <= 1'b0;
         busy_q      <= 1'b0;
         settleCnt_q <= '0;
         ackCnt_q    <= '0;
      end else begin
         state_q     <= state_d;
         alpha_q     <= alpha_in_i;
         enable_q    <= enable_i;
         afeReq_q    <= afeReq_d;
         gainHi_q    <= gainHi_d;
         gainSel_q   <= gainSel_d;
         fault_q     <= fault_d;
         busy_q      <= busy_d;
         settleCnt_q <= settleCnt_d;
         ackCnt_q    <= ackCnt_d;
      end
   end

   mix_ramp_gen #(
      .WEIGHT_W(WEIGHT_W)
   ) u_ramp (
      .CLK_3M      (CLK_3M),
      .reset       (reset),
      .clr_i       (rampClr),
      .step_i      (rampStep),
      .ramp_shift_i(ramp_shift_i),
      .weight_o    (rampWeight),
      .full_o      (rampFull)
   );

   assign afe_req_o     = afeReq_q;
   assign afe_gain_hi_o = gainHi_q;
   assign gain_sel_o    = gainSel_q;
   assign mix_weight_o  = rampWeight;
   assign busy_o        = busy_q;
   assign fault_o       = fault_q;

endmodule
